// File: rtl/filter_cfg_sequencer.sv
// filter_cfg_sequencer: Avalon-MM shadow configuration for the image filter pipe.
// Shadow registers are copied to the active outputs only at a frame boundary
// (or straight away while idle), and pipe start/stop is aligned to frame start.
// Optional build macro: FILTER_FRAME_CNT_EN adds a 16-bit FRAME_CNT at word 13.
module filter_cfg_sequencer #(
  parameter logic [10:0] SOF_H = 11'd0,
  parameter logic [9:0]  SOF_V = 10'd0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Clock_en,
  input  logic [10:0] H_Count,
  input  logic [9:0]  V_Count,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        Enable,
  output logic [31:0] Filter_config,
  output logic [31:0] C_m1_m1,
  output logic [31:0] C_m1_0,
  output logic [31:0] C_m1_p1,
  output logic [31:0] C_0_m1,
  output logic [31:0] C_0_0,
  output logic [31:0] C_0_p1,
  output logic [31:0] C_p1_m1,
  output logic [31:0] C_p1_0,
  output logic [31:0] C_p1_p1,
  output logic [31:0] C_ws
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SOF  = 2'd1,
    S_RUN       = 2'd2,
    S_STOP_PEND = 2'd3
  } state_t;

  // Config block: entry 0 = CONFIG, 1..9 = coefficients, 10 = C_ws (word addr 2..12)
  localparam int NREG = 11;
  // Everything zero except C_0_0 (entry 5) = 1: an identity filter
  localparam logic [NREG-1:0][31:0] CFG_RST = 352'd1 << 160;

  state_t                r_state, w_next;
  logic                  r_run_req, r_pend;
  logic [NREG-1:0][31:0] r_sh, r_act;
  logic [31:0]           r_rdata, w_rmux, w_fc_rd;
  logic                  w_sof, w_wr, w_rd, w_commit, w_apply, w_cfg_sel;
  logic [3:0]            w_idx;

  assign w_sof     = Clock_en && (H_Count == SOF_H) && (V_Count == SOF_V);
  assign w_wr      = chipselect && write;
  assign w_rd      = chipselect && read;
  assign w_commit  = w_wr && (address == 4'd0) && writedata[1];
  assign w_cfg_sel = (address >= 4'd2) && (address <= 4'd12);
  assign w_idx     = address - 4'd2;
  // Apply looks at the registered pending flag, so a commit written on a sof
  // cycle waits for the next sof.
  assign w_apply   = r_pend && ((r_state == S_IDLE) || w_sof);

  // FSM state register
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;

  // FSM next-state: start/stop requests take effect on sof; a reversed request cancels
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (r_run_req) w_next = S_WAIT_SOF;
      S_WAIT_SOF:  if (!r_run_req) w_next = S_IDLE;
                   else if (w_sof) w_next = S_RUN;
      S_RUN:       if (!r_run_req) w_next = S_STOP_PEND;
      S_STOP_PEND: if (r_run_req) w_next = S_RUN;
                   else if (w_sof) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FSM output: pipe runs in RUN and until the stopping frame ends
  always_comb Enable = (r_state == S_RUN) || (r_state == S_STOP_PEND);

  // CTRL run request and commit pending flag; a commit while pending is a no-op
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      r_run_req <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      if (w_wr && address == 4'd0) r_run_req <= writedata[0];
      if (w_apply)       r_pend <= 1'b0;
      else if (w_commit) r_pend <= 1'b1;
    end

  // Shadow and active config; active copies the pre-write shadow on apply
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      r_sh  <= CFG_RST;
      r_act <= CFG_RST;
    end else begin
      if (w_wr && w_cfg_sel) r_sh[w_idx] <= writedata;
      if (w_apply)           r_act <= r_sh;
    end

`ifdef FILTER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  // Frames run with the pipe enabled; any write clears
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn)                        r_frame_cnt <= 16'd0;
    else if (w_wr && address == 4'd13)  r_frame_cnt <= 16'd0;
    else if (w_sof && Enable)           r_frame_cnt <= r_frame_cnt + 16'd1;
  assign w_fc_rd = {16'd0, r_frame_cnt};
`else
  assign w_fc_rd = 32'd0;
`endif

  // Read mux: shadow values only, never active ones
  always_comb begin
    w_rmux = 32'd0;
    case (address)
      4'd0:    w_rmux = {31'd0, r_run_req};
      4'd1:    w_rmux = {28'd0, r_state, r_pend, Enable};
      4'd13:   w_rmux = w_fc_rd;
      default: if (w_cfg_sel) w_rmux = r_sh[w_idx];
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn)   r_rdata <= 32'd0;
    else if (w_rd) r_rdata <= w_rmux;

  assign readdata      = r_rdata;
  assign Filter_config = r_act[0];
  assign C_m1_m1       = r_act[1];
  assign C_m1_0        = r_act[2];
  assign C_m1_p1       = r_act[3];
  assign C_0_m1        = r_act[4];
  assign C_0_0         = r_act[5];
  assign C_0_p1        = r_act[6];
  assign C_p1_m1       = r_act[7];
  assign C_p1_0        = r_act[8];
  assign C_p1_p1       = r_act[9];
  assign C_ws          = r_act[10];
endmodule

// File: tb/tb_filter_cfg_sequencer.sv
// Bench for filter_cfg_sequencer: reset/readback tables, directed frame
// sequences and randomized traffic against a frame-level reference model.
module tb_filter_cfg_sequencer;
  logic        Clock = 1'b0, Resetn = 1'b0, Clock_en = 1'b0;
  logic [10:0] H_Count = 11'd5;
  logic [9:0]  V_Count = 10'd100;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata, Filter_config, C_ws;
  logic [31:0] C_m1_m1, C_m1_0, C_m1_p1, C_0_m1, C_0_0, C_0_p1, C_p1_m1, C_p1_0, C_p1_p1;
  logic        Enable;

  filter_cfg_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .Clock_en(Clock_en), .H_Count(H_Count), .V_Count(V_Count),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .Enable(Enable), .Filter_config(Filter_config),
    .C_m1_m1(C_m1_m1), .C_m1_0(C_m1_0), .C_m1_p1(C_m1_p1), .C_0_m1(C_0_m1), .C_0_0(C_0_0),
    .C_0_p1(C_0_p1), .C_p1_m1(C_p1_m1), .C_p1_0(C_p1_0), .C_p1_p1(C_p1_p1), .C_ws(C_ws));

  always #5 Clock = ~Clock;

  logic [31:0] dut_act [11];
  assign dut_act[0] = Filter_config; assign dut_act[1] = C_m1_m1; assign dut_act[2] = C_m1_0;
  assign dut_act[3] = C_m1_p1;       assign dut_act[4] = C_0_m1;  assign dut_act[5] = C_0_0;
  assign dut_act[6] = C_0_p1;        assign dut_act[7] = C_p1_m1; assign dut_act[8] = C_p1_0;
  assign dut_act[9] = C_p1_p1;       assign dut_act[10] = C_ws;

  int n_chk = 0, n_pass = 0;

  // Reference model. Run state is tracked as "enabled" plus the run request of
  // this and the previous cycle: a start needs the request held for a full cycle
  // before sof, a stop likewise needs it clear for a full cycle before sof.
  logic [31:0] m_sh [11], m_act [11], m_rd;
  logic        m_en, m_rr, m_rrp, m_pend;
  logic [15:0] m_fc;

  task automatic model_reset();
    for (int i = 0; i < 11; i++) begin m_sh[i] = (i == 5) ? 32'd1 : 32'd0; m_act[i] = m_sh[i]; end
    m_rd = 0; m_en = 0; m_rr = 0; m_rrp = 0; m_pend = 0; m_fc = 0;
  endtask

  function automatic logic [31:0] rmux(input logic [3:0] a);
    if (a == 4'd0) return {31'd0, m_rr};
    if (a == 4'd1) return {28'd0, m_en, (m_en ? !m_rrp : m_rrp), m_pend, m_en};
    if (a >= 4'd2 && a <= 4'd12) return m_sh[a - 4'd2];
`ifdef FILTER_FRAME_CNT_EN
    if (a == 4'd13) return {16'd0, m_fc};
`endif
    return 32'd0;
  endfunction

  task automatic model_step();
    logic sof, wr, idle, apply, n_en;
    sof   = Clock_en && H_Count == 11'd0 && V_Count == 10'd0;
    wr    = chipselect && write;
    idle  = !m_en && !m_rrp;
    apply = m_pend && (idle || sof);
    if (chipselect && read) m_rd = rmux(address);
    n_en = m_en ? !(sof && !m_rr && !m_rrp) : (sof && m_rr && m_rrp);
    if (wr && address == 4'd13) m_fc = 0; else if (sof && m_en) m_fc = m_fc + 16'd1;
    if (apply) for (int i = 0; i < 11; i++) m_act[i] = m_sh[i];
    if (apply) m_pend = 0; else if (wr && address == 4'd0 && writedata[1]) m_pend = 1;
    if (wr && address >= 4'd2 && address <= 4'd12) m_sh[address - 4'd2] = writedata;
    m_rrp = m_rr;
    if (wr && address == 4'd0) m_rr = writedata[0];
    m_en = n_en;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_model();
    chk("Enable", {31'd0, Enable}, {31'd0, m_en});
    chk("readdata", readdata, m_rd);
    for (int i = 0; i < 11; i++) chk($sformatf("active%0d", i), dut_act[i], m_act[i]);
  endtask

  // One clock: mode 0 = mid-frame, 1 = sof, 2 = sof position but Clock_en low
  task automatic cyc(input logic [3:0] a, input logic cs, input logic rd, input logic wr,
                     input logic [31:0] wd, input int mode);
    address = a; chipselect = cs; read = rd; write = wr; writedata = wd;
    Clock_en = (mode != 2);
    H_Count  = (mode == 0) ? 11'd37 : 11'd0;
    V_Count  = (mode == 0) ? 10'd100 : 10'd0;
    model_step();
    @(posedge Clock); @(negedge Clock);
    chipselect = 0; read = 0; write = 0;
    check_model();
  endtask

  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic sof(); cyc(0, 0, 0, 0, 0, 1); endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d); cyc(a, 1, 0, 1, d, 0); endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d); cyc(a, 1, 1, 0, 0, 0); d = readdata; endtask

  task automatic async_reset();
    #2 Resetn = 0; model_reset();
    #1 chk("async_Enable", {31'd0, Enable}, 32'd0);
    check_model();
    @(posedge Clock); @(negedge Clock); Resetn = 1;
  endtask

  typedef struct { logic do_wr; logic [3:0] a; logic [31:0] wd; logic [31:0] exp; } vec_t;
  vec_t tv_rst [16];
  vec_t tv_wr  [8];

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 16; i++) tv_rst[i] = '{1'b0, 4'(i), 32'd0, (i == 7) ? 32'd1 : 32'd0};
    tv_wr[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tv_wr[1] = '{1'b1, 4'd11, 32'h1234_5678, 32'h1234_5678};
    tv_wr[2] = '{1'b1, 4'd12, 32'h0000_001F, 32'h0000_001F};
    tv_wr[3] = '{1'b1, 4'd2,  32'h0000_0003, 32'h0000_0003};
    tv_wr[4] = '{1'b1, 4'd1,  32'hFFFF_FFFF, 32'h0};
    tv_wr[5] = '{1'b1, 4'd14, 32'hAAAA_AAAA, 32'h0};
    tv_wr[6] = '{1'b1, 4'd15, 32'h5555_5555, 32'h0};
    tv_wr[7] = '{1'b1, 4'd13, 32'h0000_0077, 32'h0};

    model_reset();
    repeat (3) @(negedge Clock);
    chk("reset_Enable", {31'd0, Enable}, 32'd0);
    Resetn = 1;
    check_model();

    // Reset readback and shadow write/readback tables
    foreach (tv_rst[i]) begin rd(tv_rst[i].a, d); chk($sformatf("rst_rd%0d", i), d, tv_rst[i].exp); end
    foreach (tv_wr[i]) begin
      if (tv_wr[i].do_wr) wr(tv_wr[i].a, tv_wr[i].wd);
      rd(tv_wr[i].a, d); chk($sformatf("wr_rd%0d", i), d, tv_wr[i].exp);
    end

    // Commit while idle
    wr(2, 5); wr(12, 4); wr(0, 2); idle(1);
    chk("idle_commit_cfg", Filter_config, 5); chk("idle_commit_ws", C_ws, 4);
    rd(1, d); chk("idle_commit_pend", {31'd0, d[1]}, 0);

    // Start aligned to sof
    wr(0, 1); idle(3);
    chk("start_wait_en", {31'd0, Enable}, 0);
    sof();
    chk("start_en", {31'd0, Enable}, 1);
    rd(1, d); chk("start_state", {30'd0, d[3:2]}, 2);

    // Mid-frame commit waits for sof
    wr(7, 7); wr(0, 3); idle(2);
    chk("run_commit_hold", C_0_0, 1);
    rd(1, d); chk("run_commit_pend", {31'd0, d[1]}, 1);
    sof();
    chk("run_commit_apply", C_0_0, 7);

    // Commit written on the sof cycle waits a frame
    wr(12, 9); cyc(0, 1, 0, 1, 3, 1);
    chk("sof_commit_hold0", C_ws, 4);
    idle(2); chk("sof_commit_hold1", C_ws, 4);
    sof(); chk("sof_commit_apply", C_ws, 9);

    // Stop aligned to sof
    wr(0, 0); idle(2);
    chk("stop_pend_en", {31'd0, Enable}, 1);
    rd(1, d); chk("stop_pend_state", {30'd0, d[3:2]}, 3);
    sof(); chk("stop_en", {31'd0, Enable}, 0);

    // Reset in STOP_PEND with a commit pending
    wr(0, 1); idle(2); sof();
    wr(7, 3); wr(0, 2); idle(1);
    rd(1, d); chk("stop_pend_status", d, 32'hF);
    async_reset();
    chk("rst_C_0_0", C_0_0, 1);
    rd(1, d); chk("rst_status", d, 0);

`ifdef FILTER_FRAME_CNT_EN
    wr(0, 1); wr(13, 0); idle(2); sof();
    for (int f = 0; f < 3; f++) begin idle(3); sof(); end
    rd(13, d); chk("frame_cnt", d, 3);
    wr(0, 0); idle(2); sof();
`else
    rd(13, d); chk("frame_cnt_absent", d, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      int op, mode;
      logic [3:0] a;
      mode = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 15) == 0) ? 2 : 0);
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      if (i == 350) async_reset();
      if (op < 2)      cyc(0, 1, 0, 1, $urandom_range(0, 3), mode);
      else if (op < 4) cyc(a, 1, 0, 1, $urandom, mode);
      else if (op < 6) cyc(a, 1, 1, 0, 0, mode);
      else             cyc(a, $urandom_range(0, 1) == 1, 0, 0, $urandom, mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
